// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the sequencer state encoding.
package trap_ctrl_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_W_MEPC      = 3'd1,
      S_W_MSTATUS   = 3'd2,
      S_W_MCAUSE    = 3'd3,
      S_ASSERT      = 3'd4,
      S_W_MRET      = 3'd5,
      S_ASSERT_MRET = 3'd6
   } trap_state_e;

endpackage

// File: rtl/trap_ctrl.sv
// Trap sequencer: takes ecall/ebreak/mret/interrupts, issues the mepc,
// mstatus and mcause writes on the CSR secondary port, then redirects the PC.
//
// state         | meaning
// S_IDLE        | watching for events; hold asserted only in the cycle one is taken
// S_W_MEPC      | writing captured epc to mepc
// S_W_MSTATUS   | writing mstatus with MPIE<=MIE, MIE<=0
// S_W_MCAUSE    | writing captured cause to mcause
// S_ASSERT      | redirect PC to mtvec
// S_W_MRET      | writing mstatus with MIE<=MPIE, MPIE<=1
// S_ASSERT_MRET | redirect PC to mepc
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int          INT_W       = 8,
   parameter logic [31:0] CAUSE_TIMER = 32'h8000_0007,
   parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ecall_i,
   input  logic             ebreak_i,
   input  logic             mret_i,
   input  logic [31:0]      inst_addr_i,
   input  logic             jump_flag_i,
   input  logic [31:0]      jump_addr_i,
   input  logic [INT_W-1:0] int_flag_i,
   input  logic             global_int_en_i,
   input  logic [31:0]      csr_mtvec_i,
   input  logic [31:0]      csr_mepc_i,
   input  logic [31:0]      csr_mstatus_i,
   output logic             csr_we_o,
   output logic [31:0]      csr_waddr_o,
   output logic [31:0]      csr_wdata_o,
   output logic             hold_flag_o,
   output logic             int_assert_o,
   output logic [31:0]      int_addr_o
);

   trap_state_e state_q, state_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cause_q, cause_d;
   logic        hold_d;

   logic        we_d;
   logic [31:0] waddr_d;
   logic [31:0] wdata_d;
   logic        assert_d;
   logic [31:0] iaddr_d;

   logic [31:0] mst_trap;
   logic [31:0] mst_mret;

   always_comb begin
      mst_trap               = csr_mstatus_i;
      mst_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
      mst_trap[MSTATUS_MIE]  = 1'b0;
      mst_mret               = csr_mstatus_i;
      mst_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
      mst_mret[MSTATUS_MPIE] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      hold_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            hold_d = 1'b0;
            if (ecall_i || ebreak_i) begin
               epc_d   = inst_addr_i;
               cause_d = ecall_i ? CAUSE_ECALL : CAUSE_EBREAK;
               state_d = S_W_MEPC;
               hold_d  = 1'b1;
            end else if (mret_i) begin
               state_d = S_W_MRET;
               hold_d  = 1'b1;
            end else if (global_int_en_i && (|int_flag_i)) begin
               epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
               cause_d = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
               state_d = S_W_MEPC;
               hold_d  = 1'b1;
            end
         end
         S_W_MEPC:      state_d = S_W_MSTATUS;
         S_W_MSTATUS:   state_d = S_W_MCAUSE;
         S_W_MCAUSE:    state_d = S_ASSERT;
         S_ASSERT:      state_d = S_IDLE;
         S_W_MRET:      state_d = S_ASSERT_MRET;
         S_ASSERT_MRET: state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so each write lands in its own state cycle.
   always_comb begin
      we_d     = 1'b0;
      waddr_d  = 32'd0;
      wdata_d  = 32'd0;
      assert_d = 1'b0;
      iaddr_d  = 32'd0;
      case (state_d)
         S_W_MEPC: begin
            we_d    = 1'b1;
            waddr_d = {20'd0, CSR_MEPC};
            wdata_d = epc_d;
         end
         S_W_MSTATUS: begin
            we_d    = 1'b1;
            waddr_d = {20'd0, CSR_MSTATUS};
            wdata_d = mst_trap;
         end
         S_W_MCAUSE: begin
            we_d    = 1'b1;
            waddr_d = {20'd0, CSR_MCAUSE};
            wdata_d = cause_d;
         end
         S_W_MRET: begin
            we_d    = 1'b1;
            waddr_d = {20'd0, CSR_MSTATUS};
            wdata_d = mst_mret;
         end
         S_ASSERT: begin
            assert_d = 1'b1;
            iaddr_d  = csr_mtvec_i;
         end
         S_ASSERT_MRET: begin
            assert_d = 1'b1;
            iaddr_d  = csr_mepc_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         epc_q        <= 32'd0;
         cause_q      <= 32'd0;
         csr_we_o     <= 1'b0;
         csr_waddr_o  <= 32'd0;
         csr_wdata_o  <= 32'd0;
         int_assert_o <= 1'b0;
         int_addr_o   <= 32'd0;
      end else begin
         state_q      <= state_d;
         epc_q        <= epc_d;
         cause_q      <= cause_d;
         csr_we_o     <= we_d;
         csr_waddr_o  <= waddr_d;
         csr_wdata_o  <= wdata_d;
         int_assert_o <= assert_d;
         int_addr_o   <= iaddr_d;
      end
   end

   assign hold_flag_o = hold_d && !rst;

endmodule
